osc_freq_meter: RTL and testbench
=================================

OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 Parameter NUM_CH, default 4: number of oscillator input channels, 1..16.
REQ-002 Parameter CNT_W, default 16: width of the edge counter and result.
REQ-003 Parameter GATE_W, default 16: width of the gate-length field.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 osc_in  input  NUM_CH  asynchronous oscillator outputs to be measured.
REQ-008 ch_sel  input  clog2(NUM_CH) (min 1)  channel to measure; sampled with start.
REQ-009 gate_len  input  GATE_W  measurement window in clk cycles; sampled with start.
REQ-010 start  input  1  single-cycle request to begin a measurement.
REQ-011 cont  input  1  continuous mode; sampled with start.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 res_count  output  CNT_W  rising-edge count of the last completed window.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-016 res_ovf  output  1  count exceeded 2^CNT_W-1 in this window.

Function
REQ-017 Every osc_in bit has a 2-flop synchroniser plus a history flop; edge = sync2 & ~hist. Synchronisers run in all states.
REQ-018 Edges are counted only from the channel captured at start. Input frequency < clk/2 is required for exact counts.
REQ-019 FSM states: IDLE, ARM, GATE, DONE.
REQ-020 IDLE: start=1 with gate_len!=0 captures ch_sel, gate_len and cont, then goes to ARM. start with gate_len==0 is ignored.
REQ-021 ARM lasts 1 cycle. It clears the counter and res_ovf and loads the gate down-counter with gate_len, then goes to GATE.
REQ-022 GATE lasts exactly gate_len cycles. In each of those cycles the counter increments by 1 if the selected edge is high.
REQ-023 On the last GATE cycle the next state is DONE. res_count and res_ovf are registered, and res_valid=1 from the first DONE cycle.
REQ-024 DONE holds res_count, res_ovf and res_valid stable until res_valid&res_ready.
REQ-025 On DONE handshake: if the captured cont=1, go to ARM reusing the captured settings; otherwise go to IDLE. res_valid drops in the cycle after the handshake.
REQ-026 start is ignored in ARM, GATE and DONE. ch_sel, gate_len and cont changes outside the start cycle have no effect.
REQ-027 In continuous mode, deasserting cont has no effect. Only rst stops continuous measurement.
REQ-028 Counter overflow behaviour is set by REQ-032/033.

Reset
REQ-029 rst=1 at any clock edge, including mid-window, forces IDLE and clears counter, gate counter, synchroniser and history flops and captured settings.
REQ-030 During reset and on the first cycle after it: busy=0, res_valid=0, res_count=0, res_ovf=0.
REQ-031 A window interrupted by reset produces no result.

Configuration
REQ-032 With OSC_FREQ_METER_SAT_EN defined: on overflow the counter saturates at 2^CNT_W-1 and res_ovf=1 is reported with the result.
REQ-033 Without OSC_FREQ_METER_SAT_EN: the counter wraps modulo 2^CNT_W and res_ovf is tied 0.

Verification
REQ-034 NUM_CH=4, ch 2 toggled synchronously every 5 clk, gate_len=100, start -> res_valid in the 102nd cycle after start, res_count=10, res_ovf=0.
REQ-035 Same stimulus, res_ready held 0 for 20 cycles -> res_count=10 and res_valid held for 20 cycles; res_valid=0 one cycle after res_ready=1.
REQ-036 CNT_W=8, period 2 clk, gate_len=1000 -> with SAT_EN: res_count=255, res_ovf=1; without: res_count=244, res_ovf=0.
REQ-037 cont=1, gate_len=50, period 10, res_ready=1 -> results of 5 back-to-back; a new window starts every 52 cycles; busy stays 1.
REQ-038 rst pulsed at cycle 40 of a 100-cycle window -> IDLE next cycle, busy=0, no res_valid; a later start with gate_len=0 -> busy stays 0.
REQ-039 Start issued while busy with ch_sel=3 -> ignored; the current result is still from the channel captured at start.

Source files
------------

// File: rtl/osc_freq_meter.sv
// Gated edge counter for one of NUM_CH asynchronous oscillator inputs.
// Optional build macro OSC_FREQ_METER_SAT_EN: saturate the counter and report overflow.
//
// state  | meaning
// IDLE   | waiting for start with a non-zero gate length
// ARM    | one cycle: clear the counter, load the gate down-counter
// GATE   | counting selected-channel edges for gate_len cycles
// DONE   | result held until the consumer takes it
module osc_freq_meter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_osc_in,
  input  logic [SEL_W-1:0]  i_ch_sel,
  input  logic [GATE_W-1:0] i_gate_len,
  input  logic              i_start,
  input  logic              i_cont,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_res_count,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_sync1, r_sync2, r_hist;
  logic [NUM_CH-1:0]   w_edge;
  logic                w_edge_sel;
  logic [SEL_W-1:0]    r_ch;
  logic [GATE_W-1:0]   r_gate_len;
  logic                r_cont;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]    r_res_count;
  logic                w_start_ok;
  logic                w_gate_last;

  // Synchronisers run in every state so a new window starts on settled history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= i_osc_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_hist;

  always_comb begin
    w_edge_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == SEL_W'(i)) w_edge_sel = w_edge[i];
    end
  end

  assign w_start_ok  = i_start && (i_gate_len != '0);
  assign w_gate_last = (r_gate_cnt == GATE_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_GATE;
      S_GATE:  if (w_gate_last) w_state_nxt = S_DONE;
      S_DONE:  if (i_res_ready) w_state_nxt = r_cont ? S_ARM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_res_valid = (r_state == S_DONE);
  end

  assign o_res_count = r_res_count;

`ifdef OSC_FREQ_METER_SAT_EN
  logic r_ovf, r_res_ovf, w_ovf_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_edge_sel) begin
      if (&r_cnt) w_ovf_nxt = 1'b1;
      else        w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf     <= 1'b0;
      r_res_ovf <= 1'b0;
    end else if (r_state == S_ARM) begin
      r_ovf     <= 1'b0;
      r_res_ovf <= 1'b0;
    end else if (r_state == S_GATE) begin
      r_ovf <= w_ovf_nxt;
      if (w_gate_last) r_res_ovf <= w_ovf_nxt;
    end
  end

  assign o_res_ovf = r_res_ovf;
`else
  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(w_edge_sel);
  end

  assign o_res_ovf = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ch        <= '0;
      r_gate_len  <= '0;
      r_cont      <= 1'b0;
      r_cnt       <= '0;
      r_gate_cnt  <= '0;
      r_res_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_ch       <= i_ch_sel;
            r_gate_len <= i_gate_len;
            r_cont     <= i_cont;
          end
        end
        S_ARM: begin
          r_cnt      <= '0;
          r_gate_cnt <= r_gate_len;
        end
        S_GATE: begin
          r_cnt      <= w_cnt_nxt;
          r_gate_cnt <= r_gate_cnt - GATE_W'(1);
          if (w_gate_last) r_res_count <= w_cnt_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Self-checking bench for osc_freq_meter: vector table, scoreboard queue and
// hand-written sequences for hold, continuous, reset and ignored-start cases.
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  osc = 4'b0;
  logic [1:0]  ch_sel;
  logic [15:0] gate_len;
  logic        start, cont, res_ready;
  logic        busy, res_valid, res_ovf;
  logic [15:0] res_count;

  logic [1:0]  ch_sel8;
  logic [15:0] gate_len8;
  logic        start8, cont8, ready8;
  logic        busy8, valid8, ovf8;
  logic [7:0]  count8;

  osc_freq_meter #(.NUM_CH(4), .CNT_W(16), .GATE_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_osc_in(osc), .i_ch_sel(ch_sel),
    .i_gate_len(gate_len), .i_start(start), .i_cont(cont),
    .o_busy(busy), .o_res_count(res_count), .o_res_valid(res_valid),
    .i_res_ready(res_ready), .o_res_ovf(res_ovf)
  );

  osc_freq_meter #(.NUM_CH(4), .CNT_W(8), .GATE_W(16)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_osc_in(osc), .i_ch_sel(ch_sel8),
    .i_gate_len(gate_len8), .i_start(start8), .i_cont(cont8),
    .o_busy(busy8), .o_res_count(count8), .o_res_valid(valid8),
    .i_res_ready(ready8), .o_res_ovf(ovf8)
  );

  // Half-periods in clk cycles; each channel toggles synchronously to clk.
  int hp[4] = '{1, 4, 5, 2};
  int oc[4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      oc[c] = oc[c] + 1;
      if (oc[c] >= hp[c]) begin
        oc[c]  = 0;
        osc[c] = ~osc[c];
      end
    end
  end

  bit mon_busy = 1'b0, busy_low_seen = 1'b0;
  bit mon_valid = 1'b0, valid_seen = 1'b0;
  always @(negedge clk) begin
    if (mon_busy && !busy) busy_low_seen = 1'b1;
    if (mon_valid && res_valid) valid_seen = 1'b1;
  end

  typedef struct {int cnt; bit ovf;} exp_t;
  exp_t sb[$];

  typedef struct {logic [1:0] ch; logic [15:0] gl;} vec_t;
  vec_t vecs[6];

  int n_checks = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int cnt, input bit ovf);
    exp_t e;
    e.cnt = cnt;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Called on a negedge; the start pulse is removed by the next negedge in wait_result.
  task automatic do_start(input logic [1:0] ch, input logic [15:0] gl, input logic c);
    start    = 1'b1;
    ch_sel   = ch;
    gate_len = gl;
    cont     = c;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int   cyc = 0;
    exp_t e;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      cont  = 1'b0;
      cyc++;
      if (res_valid || cyc > 3000) break;
    end
    check({name, "_valid"}, int'(res_valid), 1);
    if (!res_valid) return;
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_sb_nonempty"}, int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_count"}, int'(res_count), e.cnt);
      check({name, "_ovf"}, int'(res_ovf), int'(e.ovf));
    end
  endtask

  initial begin
    bit held;
    bit idle_ok;
    int cyc;

    vecs[0] = '{2'd2, 16'd100};
    vecs[1] = '{2'd0, 16'd40};
    vecs[2] = '{2'd1, 16'd80};
    vecs[3] = '{2'd3, 16'd60};
    vecs[4] = '{2'd0, 16'd2};
    vecs[5] = '{2'd1, 16'd8};

    rst = 1'b1; start = 1'b0; cont = 1'b0; ch_sel = '0; gate_len = '0; res_ready = 1'b1;
    start8 = 1'b0; cont8 = 1'b0; ch_sel8 = '0; gate_len8 = '0; ready8 = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_count", int'(res_count), 0);
    check("rst_ovf", int'(res_ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(res_valid), 0);
    check("post_rst_count", int'(res_count), 0);
    check("post_rst_ovf", int'(res_ovf), 0);
    check("post_rst_busy8", int'(busy8), 0);

    // Vector table: gate lengths are whole input periods, so counts are phase-independent.
    for (int i = 0; i < 6; i++) begin
      push_exp(int'(vecs[i].gl) / (2 * hp[vecs[i].ch]), 1'b0);
      do_start(vecs[i].ch, vecs[i].gl, 1'b0);
      wait_result($sformatf("vec%0d", i), int'(vecs[i].gl) + 2);
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", i), int'(res_valid), 0);
      check($sformatf("vec%0d_idle", i), int'(busy), 0);
    end

    // Result held while consumer stalls; a start during DONE is ignored.
    res_ready = 1'b0;
    push_exp(10, 1'b0);
    do_start(2'd2, 16'd100, 1'b0);
    wait_result("hold", 102);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) do_start(2'd3, 16'd10, 1'b0);
      else start = 1'b0;
      if (!res_valid || res_count != 16'd10) held = 1'b0;
    end
    check("hold_20_cycles", int'(held), 1);
    res_ready = 1'b1;
    @(negedge clk);
    check("hold_valid_drop", int'(res_valid), 0);
    check("hold_done_start_ignored", int'(busy), 0);

    // Continuous mode: cont is dropped right after start and must not matter.
    for (int i = 0; i < 5; i++) push_exp(5, 1'b0);
    do_start(2'd2, 16'd50, 1'b1);
    wait_result("cont0", 52);
    busy_low_seen = 1'b0;
    mon_busy = 1'b1;
    for (int i = 1; i < 5; i++) wait_result($sformatf("cont%0d", i), 52);
    mon_busy = 1'b0;
    check("cont_busy_held", int'(busy_low_seen), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cont_rst_busy", int'(busy), 0);
    check("cont_rst_valid", int'(res_valid), 0);

    // Reset in the middle of a window.
    do_start(2'd2, 16'd100, 1'b0);
    repeat (40) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(res_valid), 0);
    valid_seen = 1'b0;
    mon_valid = 1'b1;
    repeat (120) @(negedge clk);
    mon_valid = 1'b0;
    check("mid_rst_no_result", int'(valid_seen), 0);
    do_start(2'd2, 16'd0, 1'b0);
    idle_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) idle_ok = 1'b0;
    end
    check("zero_gate_ignored", int'(idle_ok), 1);

    // Start while busy on another channel is ignored.
    push_exp(10, 1'b0);
    do_start(2'd2, 16'd100, 1'b0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    do_start(2'd3, 16'd30, 1'b1);
    wait_result("busy_start", 92);
    @(negedge clk);
    check("busy_start_idle", int'(busy), 0);
    check("sb_drained", sb.size(), 0);

    // Narrow counter overflow on the 8-bit instance: 500 edges in 1000 cycles.
    ch_sel8 = 2'd0; gate_len8 = 16'd1000; start8 = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      start8 = 1'b0;
      cyc++;
      if (valid8 || cyc > 3000) break;
    end
    check("ovf8_valid", int'(valid8), 1);
    check("ovf8_latency", cyc, 1002);
`ifdef OSC_FREQ_METER_SAT_EN
    check("ovf8_count", int'(count8), 255);
    check("ovf8_flag", int'(ovf8), 1);
`else
    check("ovf8_count", int'(count8), 500 % 256);
    check("ovf8_flag", int'(ovf8), 0);
`endif
    @(negedge clk);
    check("ovf8_valid_drop", int'(valid8), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
